// File: rtl/alu_operand_seq.sv
// Operand sequencer for the 4-bit board ALU: debounces two push buttons and walks
// A -> B -> opcode -> display, committing a/b/op to the ALU atomically.
module alu_operand_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] op,
  output logic [1:0] stage,
  output logic       ready,
  output logic       commit
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Button index 0 is next, index 1 is clear.
  logic [1:0]       btn_raw;
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       pulse;
  logic             next_p;
  logic             clr_p;

  assign btn_raw = {btn_clr, btn_next};

  // Two-flop synchronizer, stability counter and accepted-level history per button.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 2'b00;
      sync   <= 2'b00;
      db     <= 2'b00;
      db_d   <= 2'b00;
      cnt[0] <= CNT_ZERO;
      cnt[1] <= CNT_ZERO;
    end else begin
      meta <= btn_raw;
      sync <= meta;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == db[i]) begin
          cnt[i] <= CNT_ZERO;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync[i];
          cnt[i] <= CNT_ZERO;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign pulse  = db & ~db_d;
  assign next_p = pulse[0];
  assign clr_p  = pulse[1];

  state_t     state, state_nxt;
  logic [3:0] a_stg, a_stg_nxt;
  logic [3:0] b_stg, b_stg_nxt;
  logic [3:0] a_nxt, b_nxt;
  logic [2:0] op_nxt;
  logic       ready_nxt;
  logic       commit_nxt;

  // State, staging and committed output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_A;
      a_stg  <= 4'h0;
      b_stg  <= 4'h0;
      a      <= 4'h0;
      b      <= 4'h0;
      op     <= 3'h0;
      ready  <= 1'b0;
      commit <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_stg  <= a_stg_nxt;
      b_stg  <= b_stg_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      op     <= op_nxt;
      ready  <= ready_nxt;
      commit <= commit_nxt;
    end
  end

  // Next-state logic; clear beats next, and an abort leaves a/b/op untouched.
  always_comb begin
    state_nxt  = state;
    a_stg_nxt  = a_stg;
    b_stg_nxt  = b_stg;
    a_nxt      = a;
    b_nxt      = b;
    op_nxt     = op;
    ready_nxt  = ready;
    commit_nxt = 1'b0;
    if (clr_p) begin
      state_nxt = S_A;
      a_stg_nxt = 4'h0;
      b_stg_nxt = 4'h0;
      ready_nxt = 1'b0;
    end else if (next_p) begin
      case (state)
        S_A: begin
          a_stg_nxt = sw;
          state_nxt = S_B;
        end
        S_B: begin
          b_stg_nxt = sw;
          state_nxt = S_OP;
        end
        S_OP: begin
          a_nxt      = a_stg;
          b_nxt      = b_stg;
          op_nxt     = sw[2:0];
          commit_nxt = 1'b1;
          ready_nxt  = 1'b1;
          state_nxt  = S_SHOW;
        end
        S_SHOW: begin
          ready_nxt = 1'b0;
          state_nxt = S_A;
        end
        default: begin
          state_nxt = S_A;
          ready_nxt = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a short debounce window (4 cycles).
module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic [1:0] stage;
  logic       ready;
  logic       commit;

  int n_cmp = 0;
  int n_err = 0;
  int commit_seen = 0;
  int base;

  alu_operand_seq #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .a(a), .b(b), .op(op), .stage(stage), .ready(ready), .commit(commit)
  );

  always #5 clk = ~clk;

  // Count commit pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (commit === 1'b1) commit_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press next for 10 cycles; the stage must move exactly on the 7th edge.
  task automatic press_chk(input logic [3:0] val, input logic [1:0] from, input logic [1:0] to);
    sw = val;
    btn_next = 1'b1;
    repeat (6) tick();
    chk("pre_adv_stage", {30'd0, stage}, {30'd0, from});
    chk("pre_adv_commit", {31'd0, commit}, 32'd0);
    tick();
    chk("adv_stage", {30'd0, stage}, {30'd0, to});
    chk("adv_commit", {31'd0, commit}, {31'd0, (to == 2'd3)});
    sw = ~val;
    repeat (3) tick();
    btn_next = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press(input logic nxt, input logic clr, input int hold);
    btn_next = nxt;
    btn_clr  = clr;
    repeat (hold) tick();
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    rst = 1'b1; sw = 4'h0; btn_next = 1'b0; btn_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_a", {28'd0, a}, 32'd0);
    chk("rst_b", {28'd0, b}, 32'd0);
    chk("rst_op", {29'd0, op}, 32'd0);
    chk("rst_stage", {30'd0, stage}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    base = commit_seen;
    repeat (50) tick();
    chk("idle_commit", commit_seen - base, 32'd0);
    chk("idle_stage", {30'd0, stage}, 32'd0);

    // Full entry
    base = commit_seen;
    press_chk(4'h3, 2'd0, 2'd1);
    press_chk(4'h5, 2'd1, 2'd2);
    press_chk(4'h1, 2'd2, 2'd3);
    chk("entry_a", {28'd0, a}, 32'h3);
    chk("entry_b", {28'd0, b}, 32'h5);
    chk("entry_op", {29'd0, op}, 32'h1);
    chk("entry_ready", {31'd0, ready}, 32'd1);
    chk("entry_stage", {30'd0, stage}, 32'd3);
    chk("entry_commits", commit_seen - base, 32'd1);

    // Short glitch is rejected
    press(1'b1, 1'b0, 3);
    chk("glitch_stage", {30'd0, stage}, 32'd3);
    chk("glitch_ready", {31'd0, ready}, 32'd1);

    // Bounce then steady: one advance only
    base = commit_seen;
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1; tick(); tick();
    btn_next = 1'b0; tick();
    press(1'b1, 1'b0, 20);
    chk("bounce_stage", {30'd0, stage}, 32'd0);
    chk("bounce_ready", {31'd0, ready}, 32'd0);
    chk("bounce_a_kept", {28'd0, a}, 32'h3);
    chk("bounce_commits", commit_seen - base, 32'd0);

    // Long hold in S_A
    sw = 4'h9;
    press(1'b1, 1'b0, 100);
    chk("hold_stage", {30'd0, stage}, 32'd1);

    // Aborts keep the committed values
    base = commit_seen;
    press(1'b0, 1'b1, 10);
    chk("clr_stage", {30'd0, stage}, 32'd0);
    sw = 4'hF;
    press_chk(4'hF, 2'd0, 2'd1);
    press(1'b0, 1'b1, 10);
    chk("abort_stage", {30'd0, stage}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_a", {28'd0, a}, 32'h3);
    chk("abort_b", {28'd0, b}, 32'h5);
    chk("abort_op", {29'd0, op}, 32'h1);
    chk("abort_commits", commit_seen - base, 32'd0);

    // Clear and next accepted on the same cycle
    press_chk(4'h2, 2'd0, 2'd1);
    press(1'b1, 1'b1, 10);
    chk("both_stage", {30'd0, stage}, 32'd0);
    chk("both_a", {28'd0, a}, 32'h3);

    // Reset during S_OP
    press_chk(4'h8, 2'd0, 2'd1);
    press_chk(4'h8, 2'd1, 2'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_a", {28'd0, a}, 32'd0);
    chk("mid_rst_b", {28'd0, b}, 32'd0);
    chk("mid_rst_op", {29'd0, op}, 32'd0);
    chk("mid_rst_stage", {30'd0, stage}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_commit", {31'd0, commit}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    press_chk(4'h8, 2'd0, 2'd1);
    press_chk(4'h8, 2'd1, 2'd2);
    press_chk(4'h7, 2'd2, 2'd3);
    chk("post_a", {28'd0, a}, 32'h8);
    chk("post_b", {28'd0, b}, 32'h8);
    chk("post_op", {29'd0, op}, 32'h7);
    chk("post_ready", {31'd0, ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
